// File: rtl/sr_flag_ctrl_if.sv
// Bundle between the SR-flag sequencer, its two requesters and the flop bank.
// The slave side is the controller; the master side is requesters plus bank.
interface sr_flag_ctrl_if #(
  parameter int NFLAG = 8,
  parameter int IDX_W = 3
);
  logic             req_a;
  logic             op_a;
  logic [IDX_W-1:0] idx_a;
  logic             ack_a;
  logic             req_b;
  logic             op_b;
  logic [IDX_W-1:0] idx_b;
  logic             ack_b;
  logic             err;
  logic [NFLAG-1:0] s_vec;
  logic [NFLAG-1:0] r_vec;
  logic [NFLAG-1:0] flag_q;
  logic             busy;
  logic [7:0]       err_cnt;

  modport slave (
    input  req_a, op_a, idx_a, req_b, op_b, idx_b, flag_q,
    output ack_a, ack_b, err, s_vec, r_vec, busy, err_cnt
  );

  modport master (
    output req_a, op_a, idx_a, req_b, op_b, idx_b, flag_q,
    input  ack_a, ack_b, err, s_vec, r_vec, busy, err_cnt
  );
endinterface

// File: rtl/sr_flag_ctrl.sv
// Round-robin sequencer for a bank of external SR flops. Each granted request
// produces one registered set or clear pulse (never both), then the bank's q
// is read back one cycle later to ack the requester with success/mismatch.
module sr_flag_ctrl #(
  parameter int NFLAG = 8,
  parameter int IDX_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  sr_flag_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             gnt_q, gnt_d;     // 1 = B owns the current operation
  logic             last_q, last_d;   // 1 = B was granted last
  logic             op_q, op_d;
  logic             rok_q, rok_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NFLAG-1:0] s_q, s_d;
  logic [NFLAG-1:0] r_q, r_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             sel_b;
  logic             sel_op;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_rok;
  logic [NFLAG-1:0] sel_hot;
  logic             rb_bit;
  logic             err_w;

  // Grant selection: B wins only if A is idle or A was served last.
  always_comb begin
    sel_b   = bus.req_b & (~bus.req_a | ~last_q);
    sel_op  = sel_b ? bus.op_b  : bus.op_a;
    sel_idx = sel_b ? bus.idx_b : bus.idx_a;
    sel_rok = 32'(sel_idx) < NFLAG;
    sel_hot = sel_rok ? (NFLAG'(1) << sel_idx) : '0;
  end

  // Readback compare; the shifted mask is zero for out-of-range indices.
  always_comb begin
    rb_bit = |(bus.flag_q & (NFLAG'(1) << idx_q));
    err_w  = (state_q == CHECK) & (~rok_q | (rb_bit != op_q));
  end

  // Next-state: pulses default to zero so they live for exactly the ISSUE cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    op_d    = op_q;
    rok_d   = rok_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    s_d     = '0;
    r_d     = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_a | bus.req_b) begin
          gnt_d   = sel_b;
          last_d  = sel_b;
          op_d    = sel_op;
          idx_d   = sel_idx;
          rok_d   = sel_rok;
          s_d     = sel_op ? sel_hot : '0;
          r_d     = sel_op ? '0 : sel_hot;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = CHECK;
      CHECK: begin
        if (err_w && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset kills any in-flight pulse without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= 1'b0;
      rok_q   <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      op_q    <= op_d;
      rok_q   <= rok_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.s_vec   = s_q;
  assign bus.r_vec   = r_q;
  assign bus.ack_a   = (state_q == CHECK) & ~gnt_q;
  assign bus.ack_b   = (state_q == CHECK) &  gnt_q;
  assign bus.err     = err_w;
  assign bus.busy    = state_q != IDLE;
  assign bus.err_cnt = cnt_q;

endmodule

// File: tb/tb_sr_flag_ctrl.sv
// Scoreboard bench: stimulus pushes the expected ack owner/err/err_cnt, and a
// per-DUT monitor pops and compares on every ack. One 8-flag instance carries
// the main sequence; a 6-flag instance covers out-of-range indices.
module tb_sr_flag_ctrl;

  typedef struct {
    logic       who;   // 0 = A, 1 = B
    logic       err;
    logic [7:0] cnt;   // err_cnt visible during the ack cycle
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int ecnt8 = 0;
  exp_t q8[$];
  exp_t q6[$];

  sr_flag_ctrl_if #(.NFLAG(8), .IDX_W(3)) b8();
  sr_flag_ctrl_if #(.NFLAG(6), .IDX_W(3)) b6();

  sr_flag_ctrl #(.NFLAG(8), .IDX_W(3)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
  sr_flag_ctrl #(.NFLAG(6), .IDX_W(3)) u6 (.clk(clk), .rst(rst), .bus(b6.slave));

  // External flop banks; frc forces q bits low to fake a stuck flop.
  logic [7:0] bank8 = '0;
  logic [7:0] frc8  = '0;
  logic [5:0] bank6 = '0;
  always @(posedge clk) bank8 <= (bank8 | b8.s_vec) & ~b8.r_vec;
  always @(posedge clk) bank6 <= (bank6 | b6.s_vec) & ~b6.r_vec;
  assign b8.flag_q = bank8 & ~frc8;
  assign b6.flag_q = bank6;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor for the 8-flag instance: invariants every cycle, scoreboard on ack.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ovl8", b8.s_vec & b8.r_vec, 0);
      chk("hot8", 32'($countones(b8.s_vec | b8.r_vec) <= 1), 1);
      if (b8.ack_a && b8.ack_b) chk("ack_both8", 1, 0);
      if (b8.ack_a || b8.ack_b) begin
        if (q8.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexp_ack8: got ack_a=%0b ack_b=%0b expected none", b8.ack_a, b8.ack_b);
        end else begin
          exp_t x;
          x = q8.pop_front();
          chk("who8", b8.ack_b, x.who);
          chk("err8", b8.err, x.err);
          chk("cnt8", b8.err_cnt, x.cnt);
        end
      end
    end
  end

  // Monitor for the 6-flag instance.
  always @(negedge clk) begin
    if (!rst && (b6.ack_a || b6.ack_b)) begin
      if (q6.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexp_ack6: got ack_a=%0b ack_b=%0b expected none", b6.ack_a, b6.ack_b);
      end else begin
        exp_t x;
        x = q6.pop_front();
        chk("who6", b6.ack_b, x.who);
        chk("err6", b6.err, x.err);
        chk("cnt6", b6.err_cnt, x.cnt);
      end
    end
  end

  // One lone request on the 8-flag instance with fixed grant/pulse/ack timing.
  task automatic do_op(input logic who, input logic op, input logic [2:0] idx,
                       input logic e_err, input string nm);
    exp_t x;
    logic [7:0] hot;
    x.who = who; x.err = e_err; x.cnt = 8'(ecnt8);
    q8.push_back(x);
    if (e_err && ecnt8 != 255) ecnt8++;
    hot = 8'd1 << idx;
    @(negedge clk);
    if (!who) begin b8.req_a = 1'b1; b8.op_a = op; b8.idx_a = idx; end
    else      begin b8.req_b = 1'b1; b8.op_b = op; b8.idx_b = idx; end
    @(negedge clk);
    chk({nm, "_s"}, b8.s_vec, op ? hot : 8'd0);
    chk({nm, "_r"}, b8.r_vec, op ? 8'd0 : hot);
    @(negedge clk);
    chk({nm, "_ack"}, who ? b8.ack_b : b8.ack_a, 1);
    chk({nm, "_clr"}, b8.s_vec | b8.r_vec, 0);
    b8.req_a = 1'b0; b8.req_b = 1'b0;
  endtask

  initial begin
    b8.req_a = 0; b8.op_a = 0; b8.idx_a = 0; b8.req_b = 0; b8.op_b = 0; b8.idx_b = 0;
    b6.req_a = 0; b6.op_a = 0; b6.idx_a = 0; b6.req_b = 0; b6.op_b = 0; b6.idx_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_s", b8.s_vec, 0);
    chk("rst_r", b8.r_vec, 0);
    chk("rst_busy", b8.busy, 0);
    chk("rst_ack", {b8.ack_a, b8.ack_b}, 0);
    chk("rst_cnt", b8.err_cnt, 0);
    rst = 1'b0;

    // Reset in the middle of ISSUE: pulse must vanish asynchronously, no ack.
    @(negedge clk);
    b8.req_a = 1'b1; b8.op_a = 1'b1; b8.idx_a = 3'd3;
    @(posedge clk);
    #2 chk("pre_rst_s", b8.s_vec, 8'h08);
    #1 rst = 1'b1;
    #1;
    chk("async_s", b8.s_vec, 0);
    chk("async_r", b8.r_vec, 0);
    chk("async_busy", b8.busy, 0);
    chk("async_cnt", b8.err_cnt, 0);
    b8.req_a = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      logic saw;
      saw = 1'b0;
      repeat (5) begin @(negedge clk); saw |= b8.ack_a | b8.ack_b; end
      chk("no_ack_after_rst", saw, 0);
    end
    chk("rst_bank3", bank8[3], 0);

    // Single set of flag 3 by A.
    do_op(1'b0, 1'b1, 3'd3, 1'b0, "set3");
    @(negedge clk);
    chk("bank3", bank8[3], 1);
    chk("idle_busy", b8.busy, 0);

    // Lone B clear (already clear) leaves last_grant = B.
    do_op(1'b1, 1'b0, 3'd2, 1'b0, "clr2");

    // Contention: both held, grants must alternate A, B, A, B.
    begin
      exp_t x;
      int n;
      x.err = 1'b0; x.cnt = 8'(ecnt8);
      for (int i = 0; i < 4; i++) begin x.who = i[0]; q8.push_back(x); end
      n = 0;
      @(negedge clk);
      b8.req_a = 1'b1; b8.op_a = 1'b0; b8.idx_a = 3'd0;
      b8.req_b = 1'b1; b8.op_b = 1'b1; b8.idx_b = 3'd7;
      for (int c = 0; c < 40 && n < 4; c++) begin
        @(negedge clk);
        if (b8.s_vec != 0) chk("cont_s", b8.s_vec, 8'h80);
        if (b8.r_vec != 0) chk("cont_r", b8.r_vec, 8'h01);
        if (b8.ack_a || b8.ack_b) n++;
        if (n == 4) begin b8.req_a = 1'b0; b8.req_b = 1'b0; end
      end
      chk("cont_acks", n, 4);
      b8.req_a = 1'b0; b8.req_b = 1'b0;
    end
    @(negedge clk);
    chk("bank7", bank8[7], 1);

    // Mismatch: flop 5 stuck low while B sets it.
    frc8 = 8'h20;
    do_op(1'b1, 1'b1, 3'd5, 1'b1, "mis5");
    @(negedge clk);
    chk("mis_cnt", b8.err_cnt, 1);
    frc8 = 8'h00;

    // Saturation: 300 mismatches, err_cnt must stop at 255.
    frc8 = 8'h10;
    for (int i = 0; i < 300; i++) do_op(1'b0, 1'b1, 3'd4, 1'b1, "sat");
    @(negedge clk);
    chk("sat_cnt", b8.err_cnt, 255);
    frc8 = 8'h00;

    // Out of range on the 6-flag instance: no pulse, ack with err.
    begin
      exp_t x;
      x.who = 1'b0; x.err = 1'b1; x.cnt = 8'd0;
      q6.push_back(x);
      @(negedge clk);
      b6.req_a = 1'b1; b6.op_a = 1'b1; b6.idx_a = 3'd7;
      @(negedge clk);
      chk("oor_pulse1", b6.s_vec | b6.r_vec, 0);
      chk("oor_busy", b6.busy, 1);
      @(negedge clk);
      chk("oor_pulse2", b6.s_vec | b6.r_vec, 0);
      chk("oor_ack", b6.ack_a, 1);
      b6.req_a = 1'b0;
      @(negedge clk);
      chk("oor_cnt", b6.err_cnt, 1);
      chk("oor_bank", bank6, 0);

      x.who = 1'b0; x.err = 1'b0; x.cnt = 8'd1;
      q6.push_back(x);
      b6.req_a = 1'b1; b6.op_a = 1'b1; b6.idx_a = 3'd5;
      @(negedge clk);
      chk("top_s6", b6.s_vec, 6'h20);
      @(negedge clk);
      chk("top_ack6", b6.ack_a, 1);
      b6.req_a = 1'b0;
      @(negedge clk);
      chk("top_bank6", bank6[5], 1);
    end

    repeat (3) @(negedge clk);
    chk("q8_empty", q8.size(), 0);
    chk("q6_empty", q6.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
